// File: rtl/nrf_pkg.sv
// Shared opcodes, state encodings and the nRF24L01 power-on configuration table
// used by the TX sequencer and its byte issuer.
package nrf_pkg;

  localparam logic [7:0] W_REGISTER   = 8'h20;
  localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] FLUSH_TX     = 8'hE1;
  localparam logic [7:0] NOP          = 8'hFF;

  localparam logic [7:0] STATUS_WR    = W_REGISTER | 8'h07;
  localparam logic [7:0] STATUS_CLR   = 8'h70;

  localparam int unsigned STAT_TX_DS  = 5;
  localparam int unsigned STAT_MAX_RT = 4;

  localparam int unsigned CFG_ENTRIES = 5;

  typedef enum logic [3:0] {
    ST_CFG,
    ST_PWRUP,
    ST_IDLE,
    ST_FLUSH,
    ST_LOAD,
    ST_CE_PULSE,
    ST_POLL,
    ST_CLEAR,
    ST_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    BI_IDLE,
    BI_LEAD,
    BI_ISSUE,
    BI_WAIT,
    BI_GAP
  } bi_state_e;

  // Returns {register address, value} for config-table entry idx.
  function automatic logic [15:0] cfg_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    cfg_entry = {8'h00, 8'h0E};
      3'd1:    cfg_entry = {8'h01, 8'h00};
      3'd2:    cfg_entry = {8'h04, 8'h00};
      3'd3:    cfg_entry = {8'h05, 8'h4C};
      default: cfg_entry = {8'h06, 8'h06};
    endcase
  endfunction

endpackage

// File: rtl/nrf_byte_issuer.sv
// Issues one multi-byte SPI command: frames CSN, requests each byte from the
// caller by index, waits for each done and guarantees a 2-cycle CSN-low gap.
module nrf_byte_issuer
  import nrf_pkg::*;
#(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_go_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic [LEN_W-1:0] byte_idx_o,
  input  logic [7:0]       byte_i,
  output logic             cmd_done_o,
  output logic [7:0]       rdata_o,
  output logic             spi_start_o,
  output logic [7:0]       spi_data_o,
  input  logic             spi_done_i,
  input  logic [7:0]       spi_rdata_i,
  output logic             csn_hold_o
);

  bi_state_e        state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       rdata_q, rdata_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BI_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rdata_d = rdata_q;
    case (state_q)
      BI_IDLE: begin
        if (cmd_go_i && (cmd_len_i != '0)) begin
          len_d   = cmd_len_i;
          idx_d   = '0;
          state_d = BI_LEAD;
        end
      end
      BI_LEAD:  state_d = BI_ISSUE;
      BI_ISSUE: state_d = BI_WAIT;
      BI_WAIT: begin
        // Done pulses outside WAIT are stray and deliberately dropped.
        if (spi_done_i) begin
          rdata_d = spi_rdata_i;
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = BI_GAP;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = BI_ISSUE;
          end
        end
      end
      BI_GAP:  state_d = BI_IDLE;
      default: state_d = BI_IDLE;
    endcase
  end

  assign byte_idx_o  = idx_q;
  assign rdata_o     = rdata_q;
  assign cmd_done_o  = (state_q == BI_GAP);
  assign spi_start_o = (state_q == BI_ISSUE);
  assign csn_hold_o  = (state_q == BI_LEAD) || (state_q == BI_ISSUE) || (state_q == BI_WAIT);
  assign spi_data_o  = ((state_q == BI_ISSUE) || (state_q == BI_WAIT)) ? byte_i : '0;

endmodule

// File: rtl/nrf_tx_sequencer.sv
// nRF24L01 transmit sequencer: configures the radio, then for each send flushes
// the TX FIFO, loads the payload, pulses CE, polls STATUS and clears it.
module nrf_tx_sequencer
  import nrf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned PWRUP_CYC     = 15000,
  parameter int unsigned CE_CYC        = 120,
  parameter int unsigned POLL_MAX      = 64
) (
  input  logic                       clk_10,
  input  logic                       rst,
  input  logic                       send,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       spi_start,
  output logic [7:0]                 spi_data,
  input  logic                       spi_done,
  input  logic [7:0]                 spi_rdata,
  output logic                       csn_hold,
  output logic                       ce,
  output logic                       ready,
  output logic                       tx_ok,
  output logic                       tx_fail
);

  localparam int unsigned LEN_W   = $clog2(PAYLOAD_BYTES + 2);
  localparam int unsigned CNT_MAX = (PWRUP_CYC > CE_CYC) ? PWRUP_CYC : CE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned POLL_W  = $clog2(POLL_MAX + 1);

  tx_state_e                  state_q, state_d;
  logic [2:0]                 cfg_q, cfg_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [POLL_W-1:0]          poll_q, poll_d;
  logic                       ok_q, ok_d;
  logic                       sent_q, sent_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;

  logic                       cmd_go, cmd_done;
  logic [LEN_W-1:0]           cmd_len, byte_idx, pidx;
  logic [7:0]                 cmd_byte, rdata;
  logic [15:0]                cfg_word;
  logic [8*PAYLOAD_BYTES-1:0] pay_shift;

  nrf_byte_issuer #(.LEN_W(LEN_W)) u_issuer (
    .clk_i       (clk_10),
    .rst_i       (rst),
    .cmd_go_i    (cmd_go),
    .cmd_len_i   (cmd_len),
    .byte_idx_o  (byte_idx),
    .byte_i      (cmd_byte),
    .cmd_done_o  (cmd_done),
    .rdata_o     (rdata),
    .spi_start_o (spi_start),
    .spi_data_o  (spi_data),
    .spi_done_i  (spi_done),
    .spi_rdata_i (spi_rdata),
    .csn_hold_o  (csn_hold)
  );

  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CFG;
      cfg_q     <= '0;
      cnt_q     <= '0;
      poll_q    <= '0;
      ok_q      <= 1'b0;
      sent_q    <= 1'b0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      ok_q      <= ok_d;
      sent_q    <= sent_d;
      payload_q <= payload_d;
    end
  end

  // Byte source for the issuer, selected by current command and byte index.
  always_comb begin
    cmd_len   = '0;
    cmd_byte  = '0;
    cfg_word  = cfg_entry(cfg_q);
    pidx      = byte_idx - LEN_W'(1);
    pay_shift = payload_q >> {pidx, 3'b000};
    case (state_q)
      ST_CFG: begin
        cmd_len  = LEN_W'(2);
        cmd_byte = (byte_idx == '0) ? (W_REGISTER | cfg_word[15:8]) : cfg_word[7:0];
      end
      ST_FLUSH: begin
        cmd_len  = LEN_W'(1);
        cmd_byte = FLUSH_TX;
      end
      ST_LOAD: begin
        cmd_len  = LEN_W'(PAYLOAD_BYTES + 1);
        cmd_byte = (byte_idx == '0) ? W_TX_PAYLOAD : pay_shift[7:0];
      end
      ST_POLL: begin
        cmd_len  = LEN_W'(1);
        cmd_byte = NOP;
      end
      ST_CLEAR: begin
        cmd_len  = LEN_W'(2);
        cmd_byte = (byte_idx == '0) ? STATUS_WR : STATUS_CLR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    ok_d      = ok_q;
    sent_d    = sent_q;
    payload_d = payload_q;
    cmd_go    = 1'b0;

    // Each command state launches exactly one command per entry; sent_q
    // re-arms on completion so CFG entries and re-polls launch again.
    if ((state_q == ST_CFG) || (state_q == ST_FLUSH) || (state_q == ST_LOAD) ||
        (state_q == ST_POLL) || (state_q == ST_CLEAR)) begin
      if (!sent_q) begin
        cmd_go = 1'b1;
        sent_d = 1'b1;
      end else if (cmd_done) begin
        sent_d = 1'b0;
      end
    end

    case (state_q)
      ST_CFG: begin
        if (cmd_done) begin
          if (cfg_q == 3'(CFG_ENTRIES - 1)) begin
            cfg_d   = '0;
            cnt_d   = '0;
            state_d = ST_PWRUP;
          end else begin
            cfg_d = cfg_q + 3'd1;
          end
        end
      end
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (send) begin
          payload_d = payload;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: if (cmd_done) state_d = ST_LOAD;
      ST_LOAD: begin
        if (cmd_done) begin
          cnt_d   = '0;
          state_d = ST_CE_PULSE;
        end
      end
      ST_CE_PULSE: begin
        if (cnt_q == CNT_W'(CE_CYC - 1)) begin
          cnt_d   = '0;
          poll_d  = '0;
          state_d = ST_POLL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_POLL: begin
        if (cmd_done) begin
          if (rdata[STAT_TX_DS]) begin
            ok_d    = 1'b1;
            poll_d  = '0;
            state_d = ST_CLEAR;
          end else if (rdata[STAT_MAX_RT] || (poll_q == POLL_W'(POLL_MAX - 1))) begin
            ok_d    = 1'b0;
            poll_d  = '0;
            state_d = ST_CLEAR;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end
      end
      ST_CLEAR: if (cmd_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_CFG;
    endcase
  end

  assign ready   = (state_q == ST_IDLE);
  assign ce      = (state_q == ST_CE_PULSE);
  assign tx_ok   = (state_q == ST_DONE) && ok_q;
  assign tx_fail = (state_q == ST_DONE) && !ok_q;

endmodule

// File: doc/nrf_tx_sequencer.md
NRF_TX_SEQUENCER -- requirements
Module: nrf_tx_sequencer

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 4, payload bytes per packet (1..32).
REQ-002 SHALL have parameter PWRUP_CYC, default 15000, power-up settle cycles (1.5 ms at 10 MHz).
REQ-003 SHALL have parameter CE_CYC, default 120, CE-high cycles per packet (12 us).
REQ-004 SHALL have parameter POLL_MAX, default 64, STATUS polls before failure.
REQ-005 SHALL have ports: clk_10 in 1, the 10 MHz clock from spi_clock_divider; rst in 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports: send in 1, start-packet pulse; payload in 8*PAYLOAD_BYTES, packet data, byte 0 in bits [7:0].
REQ-007 SHALL have ports: spi_start out 1, one-cycle byte request to spi_controller start_tx; spi_data out 8, byte to spi_controller data_in.
REQ-008 SHALL have ports: spi_done in 1, byte-complete pulse from done_tx; spi_rdata in 8, byte shifted in during that transfer.
REQ-009 SHALL have ports: csn_hold out 1, CSN frame request, high for the whole of a multi-byte command; ce out 1, nRF CE pin.
REQ-010 SHALL have ports: ready out 1, idle and configured; tx_ok out 1, pulse; tx_fail out 1, pulse.

Function
REQ-011 Byte issue: spi_start high exactly one cycle with spi_data stable; spi_data held until spi_done; next byte issued no earlier than the cycle after spi_done.
REQ-012 csn_hold SHALL rise the cycle before the first byte of a command, fall the cycle after that command's last spi_done, and stay low at least 2 cycles between commands.
REQ-013 States: CFG, PWRUP, IDLE, FLUSH, LOAD, CE_PULSE, POLL, CLEAR, DONE.
REQ-014 CFG SHALL issue each config-table entry as command {0x20|addr, value}, in table order, then go to PWRUP.
REQ-015 PWRUP SHALL count PWRUP_CYC cycles, then go to IDLE; ready SHALL be high only in IDLE.
REQ-016 IDLE: send SHALL latch payload and go to FLUSH; send in any other state SHALL be ignored.
REQ-017 FLUSH SHALL issue single-byte command 0xE1, then go to LOAD.
REQ-018 LOAD SHALL issue 0xA0 followed by payload bytes 0..PAYLOAD_BYTES-1 in one CSN frame, then go to CE_PULSE.
REQ-019 CE_PULSE SHALL drive ce high exactly CE_CYC cycles, then go to POLL.
REQ-020 POLL SHALL issue 0xFF; spi_rdata bit 5 set gives result ok; otherwise bit 4 set gives fail; otherwise re-poll; reaching POLL_MAX polls without either gives fail; any result goes to CLEAR.
REQ-021 Bits 5 and 4 both set SHALL count as ok.
REQ-022 CLEAR SHALL issue {0x27, 0x70}, then go to DONE.
REQ-023 DONE SHALL pulse tx_ok or tx_fail for one cycle per the recorded result, then go to IDLE.
REQ-024 tx_ok and tx_fail SHALL never be high in the same cycle.
REQ-025 A spi_done arriving when no byte is outstanding SHALL be ignored.

Reset
REQ-026 While rst is high: state = CFG entry 0; spi_start, csn_hold, ce, ready, tx_ok, tx_fail = 0; spi_data = 0x00; all counters = 0.
REQ-027 Reset mid-operation SHALL abandon the packet with no tx_ok or tx_fail pulse; after rst falls, configuration SHALL restart from entry 0.

Structure
REQ-028 Package nrf_pkg SHALL hold the command opcodes (W_REGISTER 0x20, W_TX_PAYLOAD 0xA0, FLUSH_TX 0xE1, NOP 0xFF) and the state encoding.
REQ-029 nrf_pkg SHALL hold the config table, in order: CONFIG 0x00=0x0E, EN_AA 0x01=0x00, SETUP_RETR 0x04=0x00, RF_CH 0x05=0x4C, RF_SETUP 0x06=0x06.
REQ-030 Sub-module nrf_byte_issuer SHALL own spi_start/spi_done sequencing and csn_hold framing, with a command-length input.

Verification
REQ-031 Reset release, bench spi_model returns done 20 cycles after each start -> bytes 20 0E, 21 00, 24 00, 25 4C, 26 06 (five frames), then ready after 15000 more cycles.
REQ-032 send with payload 0x44332211, model returns STATUS 0x0E then 0x2E -> bytes E1; A0 11 22 33 44; ce high 120 cycles; FF FF; 27 70; one tx_ok pulse.
REQ-033 STATUS returns 0x1E -> CLEAR issued, one tx_fail pulse, no tx_ok pulse.
REQ-034 STATUS always 0x0E -> exactly 64 NOP commands, then 27 70, then tx_fail.
REQ-035 send pulsed during LOAD -> ignored, payload unchanged; a spurious spi_done in IDLE -> no state change.
REQ-036 rst asserted after the third payload byte -> all outputs 0 immediately, no tx_ok or tx_fail, config restarts from 20 0E.
